// File: rtl/vram_fill.sv
// rtl/vram_fill.sv - CPU-side video-RAM fill/copy engine; copy mode enabled by VRAM_FILL_COPY_EN
module vram_fill #(
  parameter int ADDR_W = 16
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [2:0]        cpu_addr,
  input  logic [7:0]        cpu_dbw,
  input  logic              cpu_we,
  output logic [7:0]        cpu_dbr,
  output logic              halt,
  output logic              irq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dbw,
  output logic              mem_we,
  input  logic [7:0]        mem_dbr
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, CRD = 2'd2, CWR = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] dst, cnt;
  logic [7:0]        data;
  logic              done, irq_en;
  logic [15:0]       dst16, cnt16;
  logic              cpu_wr, ctrl_wr, start, last, idle;

`ifdef VRAM_FILL_COPY_EN
  logic [ADDR_W-1:0] src;
  logic [15:0]       src16;
  assign src16 = 16'(src);
`else
  logic [7:0] unused_mem_dbr;
  assign unused_mem_dbr = mem_dbr;
`endif

  assign dst16   = 16'(dst);
  assign cnt16   = 16'(cnt);
  assign idle    = (state == IDLE);
  assign cpu_wr  = sel & cpu_we;
  assign ctrl_wr = cpu_wr & (cpu_addr == 3'd7);
  assign start   = ctrl_wr & cpu_dbw[0];
  assign last    = (cnt == ADDR_W'(1));
  assign irq     = done & irq_en;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && cnt != '0) begin
`ifdef VRAM_FILL_COPY_EN
          state_nxt = cpu_dbw[1] ? CRD : FILL;
`else
          state_nxt = FILL;
`endif
        end
      end
      FILL: if (last) state_nxt = IDLE;
`ifdef VRAM_FILL_COPY_EN
      CRD:  state_nxt = CWR;
      CWR:  state_nxt = last ? IDLE : CRD;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    halt     = !idle;
    mem_we   = 1'b0;
    mem_addr = dst;
    mem_dbw  = data;
    case (state)
      FILL: mem_we = 1'b1;
`ifdef VRAM_FILL_COPY_EN
      CRD:  mem_addr = src;
      CWR: begin
        mem_we  = 1'b1;
        mem_dbw = mem_dbr;
      end
`endif
      default: ;
    endcase
  end

  // Register writes only land while idle; the engine only advances while busy.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      dst    <= '0;
      cnt    <= '0;
      data   <= '0;
      done   <= 1'b0;
      irq_en <= 1'b0;
`ifdef VRAM_FILL_COPY_EN
      src    <= '0;
`endif
    end else begin
      if (cpu_wr && idle) begin
        case (cpu_addr)
          3'd0: dst  <= ADDR_W'({dst16[15:8], cpu_dbw});
          3'd1: dst  <= ADDR_W'({cpu_dbw, dst16[7:0]});
`ifdef VRAM_FILL_COPY_EN
          3'd2: src  <= ADDR_W'({src16[15:8], cpu_dbw});
          3'd3: src  <= ADDR_W'({cpu_dbw, src16[7:0]});
`endif
          3'd4: cnt  <= ADDR_W'({cnt16[15:8], cpu_dbw});
          3'd5: cnt  <= ADDR_W'({cpu_dbw, cnt16[7:0]});
          3'd6: data <= cpu_dbw;
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en <= cpu_dbw[2];
        if (idle) done <= start && (cnt == '0);
      end
      case (state)
        FILL, CWR: begin
          dst <= dst + ADDR_W'(1);
          cnt <= cnt - ADDR_W'(1);
          if (last) done <= 1'b1;
        end
`ifdef VRAM_FILL_COPY_EN
        CRD: src <= src + ADDR_W'(1);
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_dbr = 8'h00;
    case (cpu_addr)
      3'd0: cpu_dbr = dst16[7:0];
      3'd1: cpu_dbr = dst16[15:8];
`ifdef VRAM_FILL_COPY_EN
      3'd2: cpu_dbr = src16[7:0];
      3'd3: cpu_dbr = src16[15:8];
`endif
      3'd4: cpu_dbr = cnt16[7:0];
      3'd5: cpu_dbr = cnt16[15:8];
      3'd6: cpu_dbr = data;
      3'd7: cpu_dbr = {!idle, done, 3'b000, irq_en, 2'b00};
      default: ;
    endcase
  end

endmodule
